ifu_imem_responder: RTL

- Responder end of the IFU fetch protocol: accepts fetch requests (ifu_req valid/ready + pc) and returns instruction words on the ifu_rsp channel (valid/ready + instr).
- Sits between the fetch unit and a synchronous 1-cycle-read instruction SRAM.
- Provides programmable wait states, buffers responses in a small FIFO, and flags out-of-range or misaligned fetches.

---
 rtl/ifu_imem_responder_pkg.sv | 16 +
 rtl/ifu_imem_responder_if.sv | 28 ++
 rtl/ifu_imem_rsp_fifo.sv | 51 +++++
 rtl/ifu_imem_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ifu_imem_responder_pkg.sv
// Shared definitions for the IFU instruction-memory responder.
// Holds default bus widths, the SRAM window base and the FSM state encoding.
package ifu_imem_responder_pkg;

  localparam int          PC_SIZE_D    = 32;
  localparam int          INSTR_SIZE_D = 32;
  localparam logic [31:0] MEM_BASE_D   = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RD   = 2'd2,
    ST_CAP  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_imem_responder_if.sv
// IFU fetch request/response channels plus the SRAM read port of the responder.
// master = fetch unit and SRAM side, slave = responder.
interface ifu_imem_responder_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int MEM_AW     = 16
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;
  logic                  ifu_rsp_err;
  logic                  mem_ren;
  logic [MEM_AW-1:0]     mem_addr;
  logic [INSTR_SIZE-1:0] mem_rdata;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, mem_ren, mem_addr
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, mem_ren, mem_addr
  );
endinterface

// File: rtl/ifu_imem_rsp_fifo.sv
// Generic synchronous FIFO, power-of-two DEPTH, head visible combinationally (no bypass).
// Latency: push visible one cycle later; push when full / pop when empty are ignored.
module ifu_imem_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH[AW:0]);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ifu_imem_responder.sv
// Fetch responder: one request in flight, 1-cycle SRAM read, {err,instr} queued in a FIFO; rsp_valid 3+LATENCY cycles after accept.
// Backpressure: req_ready only in IDLE/CAP with FIFO room reserved for the new request; never depends on rsp_ready.
module ifu_imem_responder
  import ifu_imem_responder_pkg::*;
#(
  parameter int                 PC_SIZE    = PC_SIZE_D,
  parameter int                 INSTR_SIZE = INSTR_SIZE_D,
  parameter logic [PC_SIZE-1:0] MEM_BASE   = MEM_BASE_D,
  parameter int                 MEM_AW     = 16,
  parameter int                 LATENCY    = 0,
  parameter int                 DEPTH      = 2
) (
  input logic                clk,
  input logic                rst,
  ifu_imem_responder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef logic [PC_SIZE:0] pc_ext_t;
  localparam pc_ext_t    WIN_LO  = pc_ext_t'(MEM_BASE);
  localparam pc_ext_t    WIN_HI  = WIN_LO + (pc_ext_t'(1) << (MEM_AW + 2));
  localparam logic [CW:0] DEPTH_X = DEPTH[CW:0];

  ifu_state_e        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] addr_r;
  logic              err_r;
  logic              mem_ren_r;
  logic [MEM_AW-1:0] mem_addr_r;

  logic              req_hs;
  logic              req_err;
  logic              in_cap;
  logic [CW:0]       cnt_need;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [INSTR_SIZE:0] push_dat;
  logic [INSTR_SIZE:0] head;

  // Compare one bit wider than the PC so a window ending at 2^PC_SIZE cannot wrap.
  assign req_err = (bus.ifu_req_pc[1:0] != 2'b00)
                 | (pc_ext_t'(bus.ifu_req_pc) < WIN_LO)
                 | (pc_ext_t'(bus.ifu_req_pc) >= WIN_HI);

  assign in_cap            = (state == ST_CAP);
  assign cnt_need          = {1'b0, fifo_cnt} + {{CW{1'b0}}, in_cap};
  assign bus.ifu_req_ready = rst & ((state == ST_IDLE) | in_cap) & (cnt_need < DEPTH_X);
  assign req_hs            = bus.ifu_req_valid & bus.ifu_req_ready;

  assign bus.mem_ren  = mem_ren_r;
  assign bus.mem_addr = mem_addr_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_r     <= '0;
      err_r      <= 1'b0;
      mem_ren_r  <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      mem_ren_r <= 1'b0;
      case (state)
        ST_IDLE, ST_CAP: begin
          if (req_hs) begin
            addr_r <= bus.ifu_req_pc[MEM_AW+1:2];
            err_r  <= req_err;
            if (LATENCY > 0) begin
              state <= ST_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end else begin
              state      <= ST_RD;
              mem_ren_r  <= ~req_err;
              mem_addr_r <= bus.ifu_req_pc[MEM_AW+1:2];
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= ST_RD;
            mem_ren_r  <= ~err_r;
            mem_addr_r <= addr_r;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_CAP;
      endcase
    end
  end

  // Faulted accesses never read the SRAM, so whatever sits on mem_rdata is masked.
  assign push_dat = {err_r, err_r ? {INSTR_SIZE{1'b0}} : bus.mem_rdata};
  assign pop      = ~fifo_empty & bus.ifu_rsp_ready;

  ifu_imem_rsp_fifo #(
    .W     (INSTR_SIZE + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (in_cap),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign bus.ifu_rsp_valid = ~fifo_empty;
  assign bus.ifu_rsp_instr = fifo_empty ? '0 : head[INSTR_SIZE-1:0];
  assign bus.ifu_rsp_err   = ~fifo_empty & head[INSTR_SIZE];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(in_cap && fifo_full));
endmodule
